mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width of all three ports.
REQ-002 SHALL have parameter DATA_W, default 16, data width of all three ports.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports i_read  input  1 / i_address  input  ADDR_W  instruction-side read request and address.
REQ-006 SHALL have ports i_resp  output  1 / i_rdata  output  DATA_W  instruction-side completion pulse and read data.
REQ-007 SHALL have ports d_read, d_write  input  1 / d_wmask  input  2 / d_address  input  ADDR_W / d_wdata  input  DATA_W  data-side request, fed by the indirect-load stage.
REQ-008 SHALL have ports d_resp  output  1 / d_rdata  output  DATA_W  data-side completion pulse and read data.
REQ-009 SHALL have ports m_read, m_write  output  1 / m_wmask  output  2 / m_address  output  ADDR_W / m_wdata  output  DATA_W  physical-memory request.
REQ-010 SHALL have ports m_resp  input  1 / m_rdata  input  DATA_W  physical-memory completion and read data.

Function
REQ-011 SHALL implement FSM states IDLE, GNT_I, GNT_D.
REQ-012 In IDLE, SHALL go to GNT_I if only i_read is high, GNT_D if only (d_read|d_write) is high, and stay in IDLE if neither is high.
REQ-013 In IDLE with both sides requesting, SHALL grant the side not served last (round-robin); last-served SHALL update on every grant.
REQ-014 On the IDLE->GNT edge, SHALL capture the granted side's read/write/wmask/address/wdata into holding registers; m_* SHALL drive only these registers.
REQ-015 m_read/m_write SHALL be high only in GNT_I/GNT_D; m_write SHALL always be 0 in GNT_I.
REQ-016 When d_read and d_write are both high at capture, SHALL treat the request as a write (m_read=0, m_write=1).
REQ-017 In GNT_x, SHALL route m_resp combinationally to x_resp; the other side's resp SHALL stay 0.
REQ-018 i_rdata and d_rdata SHALL both equal m_rdata at all times; consumers qualify with resp.
REQ-019 On m_resp in GNT_x, SHALL return to IDLE at the next edge; at least one IDLE cycle SHALL separate grants.
REQ-020 Latency: request seen in IDLE at cycle N -> m_read/m_write high in cycle N+1; x_resp in the same cycle as m_resp.
REQ-021 A requester that drops its request mid-grant SHALL NOT abort the transaction; the resp pulse SHALL still be emitted.
REQ-022 m_resp received in IDLE SHALL be ignored (no resp on either side, no state change).
REQ-023 Requesters SHALL hold their request until resp; a request still high after resp SHALL be re-arbitrated as new in the next IDLE.

Reset
REQ-024 While rst_n=0 at an edge: state<=IDLE, last-served<=D (I wins the first tie), holding registers<=0.
REQ-025 After reset, m_read, m_write, i_resp, d_resp SHALL be 0; m_address, m_wdata, m_wmask SHALL be 0.
REQ-026 Reset mid-grant SHALL abandon the transaction; m_resp arriving afterwards falls under REQ-022.

Structure
REQ-027 SHALL put the state enum (IDLE, GNT_I, GNT_D) and the requester-select enum in lc3b_types.
REQ-028 SHALL be a single flat module with no sub-modules; the round-robin pointer SHALL be a 1-bit register.

Verification
REQ-029 After reset, i_read=1 at 0x3000, m_resp after 3 cycles with m_rdata=0x1234 -> m_address=0x3000, i_resp one pulse, i_rdata=0x1234, d_resp=0.
REQ-030 d_write=1 at 0x4002, wdata=0xBEEF, wmask=2'b01 -> m_write=1, m_read=0, m_wmask=2'b01, m_wdata=0xBEEF; d_resp on m_resp.
REQ-031 i_read and d_read both held high from reset -> grants in order I, D, I, D, with one IDLE cycle between grants.
REQ-032 d_read=1 at 0x5000, then d_address changed to 0x6000 during the grant -> m_address stays 0x5000 until m_resp.
REQ-033 rst_n=0 for one cycle in GNT_D, then m_resp=1 -> m_read=0 after the edge, no d_resp, state IDLE.
REQ-034 d_read=1 and d_write=1 at 0x0010 -> write issued (m_write=1, m_read=0).

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types for the memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GNT_I, GNT_D)
//   req_sel_e   : identifies a requester (instruction or data side);
//                 used for the 1-bit round-robin pointer
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        SEL_I = 1'b0,
        SEL_D = 1'b1
    } req_sel_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port to one-port memory arbiter.
// An instruction-side reader (i_*) and a data-side reader/writer (d_*) share
// one physical memory port (m_*). Ties are broken round-robin. The granted
// request is frozen in holding registers for the whole transaction, so a
// requester may change or drop its inputs mid-grant without disturbing it.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   i_read, i_address               instruction-side request
//   i_resp, i_rdata                 instruction-side completion / read data
//   d_read, d_write, d_wmask,
//   d_address, d_wdata              data-side request
//   d_resp, d_rdata                 data-side completion / read data
//   m_read, m_write, m_wmask,
//   m_address, m_wdata              physical-memory request
//   m_resp, m_rdata                 physical-memory completion / read data
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [1:0]        d_wmask,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [DATA_W-1:0] d_rdata,

    output logic              m_read,
    output logic              m_write,
    output logic [1:0]        m_wmask,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_resp,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_e        state_reg, state_next;
    req_sel_e          last_reg, last_next;

    logic              hold_read_reg,    hold_read_next;
    logic              hold_write_reg,   hold_write_next;
    logic [1:0]        hold_wmask_reg,   hold_wmask_next;
    logic [ADDR_W-1:0] hold_address_reg, hold_address_next;
    logic [DATA_W-1:0] hold_wdata_reg,   hold_wdata_next;

    logic              i_req;
    logic              d_req;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            last_reg         <= SEL_D;   // instruction side wins the first tie
            hold_read_reg    <= 1'b0;
            hold_write_reg   <= 1'b0;
            hold_wmask_reg   <= '0;
            hold_address_reg <= '0;
            hold_wdata_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            last_reg         <= last_next;
            hold_read_reg    <= hold_read_next;
            hold_write_reg   <= hold_write_next;
            hold_wmask_reg   <= hold_wmask_next;
            hold_address_reg <= hold_address_next;
            hold_wdata_reg   <= hold_wdata_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        last_next         = last_reg;
        hold_read_next    = hold_read_reg;
        hold_write_next   = hold_write_reg;
        hold_wmask_next   = hold_wmask_reg;
        hold_address_next = hold_address_reg;
        hold_wdata_next   = hold_wdata_reg;

        case (state_reg)
            IDLE: begin
                // Instruction side wins when alone, or on a tie when the
                // data side was served last.
                if (i_req && (!d_req || last_reg == SEL_D)) begin
                    state_next        = GNT_I;
                    last_next         = SEL_I;
                    hold_read_next    = 1'b1;
                    hold_write_next   = 1'b0;
                    hold_wmask_next   = '0;
                    hold_address_next = i_address;
                    hold_wdata_next   = '0;
                end else if (d_req) begin
                    state_next        = GNT_D;
                    last_next         = SEL_D;
                    // Simultaneous read and write is treated as a write.
                    hold_read_next    = d_read & ~d_write;
                    hold_write_next   = d_write;
                    hold_wmask_next   = d_wmask;
                    hold_address_next = d_address;
                    hold_wdata_next   = d_wdata;
                end
            end
            GNT_I, GNT_D: begin
                // Always pass through IDLE so a waiting requester is
                // re-arbitrated fairly.
                if (m_resp) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobes are gated by the grant so that m_resp in IDLE, or stale holding
    // contents, can never produce a memory request or a completion pulse.
    assign m_read    = (state_reg != IDLE) & hold_read_reg;
    assign m_write   = (state_reg == GNT_D) & hold_write_reg;
    assign m_wmask   = hold_wmask_reg;
    assign m_address = hold_address_reg;
    assign m_wdata   = hold_wdata_reg;

    assign i_resp    = (state_reg == GNT_I) & m_resp;
    assign d_resp    = (state_reg == GNT_D) & m_resp;

    // Read data is broadcast; consumers qualify it with their resp.
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized run, all compared against a transaction-level ownership model.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic          i_resp;
    logic [DW-1:0] i_rdata;
    logic          d_read, d_write;
    logic [1:0]    d_wmask;
    logic [AW-1:0] d_address;
    logic [DW-1:0] d_wdata;
    logic          d_resp;
    logic [DW-1:0] d_rdata;
    logic          m_read, m_write;
    logic [1:0]    m_wmask;
    logic [AW-1:0] m_address;
    logic [DW-1:0] m_wdata;
    logic          m_resp;
    logic [DW-1:0] m_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask), .d_address(d_address),
        .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
        .m_read(m_read), .m_write(m_write), .m_wmask(m_wmask), .m_address(m_address),
        .m_wdata(m_wdata), .m_resp(m_resp), .m_rdata(m_rdata)
    );

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Reference model: who currently owns the memory port (0 none, 1 I, 2 D),
    // who was served last, and the request that was accepted.
    int            own;
    bit            last_was_d;
    logic          acc_read, acc_write;
    logic [1:0]    acc_wmask;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("m_read",    32'(m_read),    32'(own != 0 && acc_read));
        chk("m_write",   32'(m_write),   32'(own == 2 && acc_write));
        chk("m_wmask",   32'(m_wmask),   32'(acc_wmask));
        chk("m_address", 32'(m_address), 32'(acc_addr));
        chk("m_wdata",   32'(m_wdata),   32'(acc_wdata));
        chk("i_resp",    32'(i_resp),    32'(own == 1 && m_resp));
        chk("d_resp",    32'(d_resp),    32'(own == 2 && m_resp));
        chk("i_rdata",   32'(i_rdata),   32'(m_rdata));
        chk("d_rdata",   32'(d_rdata),   32'(m_rdata));
    endtask

    // Apply the rules to the inputs present at the coming clock edge.
    task automatic model_advance();
        bit want_i, want_d, pick_i;
        if (!rst_n) begin
            own = 0; last_was_d = 1'b1;
            acc_read = 0; acc_write = 0; acc_wmask = '0; acc_addr = '0; acc_wdata = '0;
        end else if (own == 0) begin
            want_i = i_read;
            want_d = d_read | d_write;
            pick_i = want_i && (!want_d || last_was_d);
            if (pick_i) begin
                own = 1; last_was_d = 1'b0;
                acc_read = 1; acc_write = 0; acc_wmask = '0;
                acc_addr = i_address; acc_wdata = '0;
            end else if (want_d) begin
                own = 2; last_was_d = 1'b1;
                acc_write = d_write; acc_read = d_read && !d_write;
                acc_wmask = d_wmask; acc_addr = d_address; acc_wdata = d_wdata;
            end
        end else if (m_resp) begin
            $display("txn %s %s addr=0x%04h wdata=0x%04h rdata=0x%04h",
                     (own == 1) ? "I" : "D", acc_write ? "WR" : "RD",
                     acc_addr, acc_wdata, m_rdata);
            own = 0;
        end
    endtask

    task automatic tick();
        #1;
        check_outputs();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_read = 0; i_address = '0;
        d_read = 0; d_write = 0; d_wmask = '0; d_address = '0; d_wdata = '0;
        m_resp = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        model_advance();
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        #1;
        chk("rst m_read",    32'(m_read),    32'h0);
        chk("rst m_write",   32'(m_write),   32'h0);
        chk("rst m_address", 32'(m_address), 32'h0);
        chk("rst m_wdata",   32'(m_wdata),   32'h0);
        chk("rst m_wmask",   32'(m_wmask),   32'h0);

        // Instruction read, response after three cycles
        i_read = 1; i_address = 16'h3000;
        tick();
        chk("ird m_address", 32'(m_address), 32'h3000);
        chk("ird m_read",    32'(m_read),    32'h1);
        tick();
        tick();
        m_resp = 1; m_rdata = 16'h1234;
        #1;
        chk("ird i_resp",  32'(i_resp),  32'h1);
        chk("ird i_rdata", 32'(i_rdata), 32'h1234);
        chk("ird d_resp",  32'(d_resp),  32'h0);
        tick();
        clear_inputs();
        #1;
        chk("ird i_resp pulse", 32'(i_resp), 32'h0);
        tick();

        // Data write
        d_write = 1; d_address = 16'h4002; d_wdata = 16'hBEEF; d_wmask = 2'b01;
        tick();
        chk("dwr m_write", 32'(m_write), 32'h1);
        chk("dwr m_read",  32'(m_read),  32'h0);
        chk("dwr m_wmask", 32'(m_wmask), 32'h1);
        chk("dwr m_wdata", 32'(m_wdata), 32'hBEEF);
        tick();
        m_resp = 1;
        #1;
        chk("dwr d_resp", 32'(d_resp), 32'h1);
        chk("dwr i_resp", 32'(i_resp), 32'h0);
        tick();
        clear_inputs();
        tick();

        // Both sides held from reset: grants alternate I, D, I, D
        i_read = 1; i_address = 16'h1000;
        d_read = 1; d_address = 16'h2000;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr grant addr", 32'(m_address), (k % 2 == 0) ? 32'h1000 : 32'h2000);
            chk("rr m_read",     32'(m_read),    32'h1);
            m_resp = 1;
            #1;
            chk("rr i_resp", 32'(i_resp), (k % 2 == 0) ? 32'h1 : 32'h0);
            chk("rr d_resp", 32'(d_resp), (k % 2 == 0) ? 32'h0 : 32'h1);
            tick();
            m_resp = 0;
            #1;
            chk("rr idle gap", 32'(m_read), 32'h0);
        end
        clear_inputs();
        tick();

        // Address change mid-grant is not seen on the memory port
        d_read = 1; d_address = 16'h5000;
        tick();
        d_address = 16'h6000;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("hold m_address", 32'(m_address), 32'h5000);
            tick();
        end
        m_resp = 1;
        #1;
        chk("hold m_address resp", 32'(m_address), 32'h5000);
        chk("hold d_resp",         32'(d_resp),    32'h1);
        tick();
        clear_inputs();
        tick();

        // Reset during a data grant abandons it
        d_read = 1; d_address = 16'h0ABC;
        tick();
        rst_n = 0;
        tick();
        rst_n = 1; d_read = 0; m_resp = 1;
        #1;
        chk("rstgnt m_read", 32'(m_read), 32'h0);
        chk("rstgnt d_resp", 32'(d_resp), 32'h0);
        tick();
        m_resp = 0;
        #1;
        chk("rstgnt idle", 32'(m_read), 32'h0);
        tick();

        // Read and write together become a write
        d_read = 1; d_write = 1; d_address = 16'h0010;
        tick();
        chk("rw m_write",   32'(m_write),   32'h1);
        chk("rw m_read",    32'(m_read),    32'h0);
        chk("rw m_address", 32'(m_address), 32'h0010);
        m_resp = 1;
        tick();
        clear_inputs();
        tick();

        // Randomized traffic, including drops, spurious responses and resets
        for (int n = 0; n < 600; n++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            i_read    = ($urandom_range(0, 3) != 0);
            d_read    = ($urandom_range(0, 2) == 0);
            d_write   = ($urandom_range(0, 2) == 0);
            d_wmask   = 2'($urandom);
            i_address = 16'($urandom);
            d_address = 16'($urandom);
            d_wdata   = 16'($urandom);
            m_resp    = ($urandom_range(0, 2) == 0);
            m_rdata   = 16'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
